// File: rtl/count_frame_scheduler.sv
// Integration-window timer and frame serialiser for the photon-counting datapath.
// Pulses latch/clear at window boundaries and streams the latched words as bytes.
module count_frame_scheduler #(
   parameter int          N_CH          = 9,
   parameter int          WINDOW_CYCLES = 5000000,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic        clock_50,
   input  logic        reset_n,
   input  logic        enable,
   output logic        counter_latch,
   output logic        counter_clear,
   output logic [3:0]  ch_sel,
   input  logic [31:0] ch_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [7:0]  overrun_cnt
);

   localparam logic [31:0] TERMINAL = 32'(WINDOW_CYCLES - 1);
   localparam logic [3:0]  LAST_CH  = 4'(N_CH - 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR_SYNC,
      HDR_NWIN,
      LOAD,
      DATA,
      CSUM
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] window_cnt;
   logic        enable_d;
   logic        start_d;
   logic        rise;
   logic        terminal;
   logic        csum_done;
   logic        latch;
   logic [7:0]  n_win;
   logic [7:0]  nwin_cap;
   logic [7:0]  csum;
   logic [3:0]  ch_idx;
   logic [1:0]  byte_idx;
   logic [31:0] word_reg;

   assign rise      = enable && !enable_d;
   assign terminal  = reset_n && enable && (window_cnt == TERMINAL);
   assign csum_done = (state == CSUM) && tx_ready;
   assign latch     = terminal && ((state == IDLE) || csum_done);

   assign counter_latch = latch;
   assign counter_clear = latch || (reset_n && start_d);

   // The clear-only cycle after an enable rise holds the counter at 0, so the
   // first window integrates the same number of cycles as every later one.
   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         window_cnt  <= '0;
         enable_d    <= 1'b0;
         start_d     <= 1'b0;
         n_win       <= 8'd1;
         overrun_cnt <= '0;
      end else begin
         enable_d <= enable;
         start_d  <= rise;
         if (!enable || rise || start_d || terminal)
            window_cnt <= '0;
         else
            window_cnt <= window_cnt + 32'd1;
         if (start_d) begin
            n_win <= 8'd1;
         end else if (terminal) begin
            if (latch) begin
               n_win <= 8'd1;
            end else begin
               if (n_win != 8'hFF)
                  n_win <= n_win + 8'd1;
               if (overrun_cnt != 8'hFF)
                  overrun_cnt <= overrun_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         state    <= IDLE;
         ch_idx   <= '0;
         byte_idx <= '0;
         word_reg <= '0;
         nwin_cap <= '0;
         csum     <= '0;
      end else begin
         state <= state_next;
         if (latch) begin
            nwin_cap <= n_win;
            csum     <= n_win;
            ch_idx   <= '0;
            byte_idx <= '0;
         end else if (state == LOAD) begin
            word_reg <= ch_data;
            byte_idx <= '0;
         end else if ((state == DATA) && tx_ready) begin
            csum     <= csum ^ tx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3)
               ch_idx <= ch_idx + 4'd1;
         end
      end
   end

   // A latch landing on the CSUM transfer chains straight into the next header.
   always_comb begin
      state_next = state;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      ch_sel     = 4'd0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (latch)
               state_next = HDR_SYNC;
         end
         HDR_SYNC: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
            if (tx_ready)
               state_next = HDR_NWIN;
         end
         HDR_NWIN: begin
            tx_valid = 1'b1;
            tx_data  = nwin_cap;
            if (tx_ready)
               state_next = LOAD;
         end
         LOAD: begin
            ch_sel     = ch_idx;
            state_next = DATA;
         end
         DATA: begin
            ch_sel   = ch_idx;
            tx_valid = 1'b1;
            tx_data  = word_reg[{byte_idx, 3'b000} +: 8];
            if (tx_ready && (byte_idx == 2'd3))
               state_next = (ch_idx == LAST_CH) ? CSUM : LOAD;
         end
         CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum;
            if (tx_ready)
               state_next = latch ? HDR_SYNC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_count_frame_scheduler.sv
// Directed bench for count_frame_scheduler with N_CH=2, WINDOW_CYCLES=100.
// A negedge monitor logs pulses and byte transfers; the main flow checks them.
module tb_count_frame_scheduler;

   logic        clock_50 = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        counter_latch;
   logic        counter_clear;
   logic [3:0]  ch_sel;
   logic [31:0] ch_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [7:0]  overrun_cnt;

   logic [31:0] ch0;
   logic [31:0] ch1;
   logic        rand_ready;

   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   int          hs_err = 0;
   logic        prev_hold = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          latch_q[$];
   int          clear_q[$];
   int          bcyc_q[$];
   logic [7:0]  byte_q[$];
   logic [7:0]  nom_exp[11];

   count_frame_scheduler #(
      .N_CH(2),
      .WINDOW_CYCLES(100),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clock_50(clock_50),
      .reset_n(reset_n),
      .enable(enable),
      .counter_latch(counter_latch),
      .counter_clear(counter_clear),
      .ch_sel(ch_sel),
      .ch_data(ch_data),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clock_50 = ~clock_50;

   assign ch_data = (ch_sel == 4'd0) ? ch0 : ch1;

   // Records events in the cycle they are visible and flags any change of a
   // held byte that was not preceded by a transfer or a reset.
   always @(negedge clock_50) begin
      cyc = cyc + 1;
      if (reset_n) begin
         if (counter_latch)
            latch_q.push_back(cyc);
         else if (counter_clear)
            clear_q.push_back(cyc);
         if (tx_valid && tx_ready) begin
            byte_q.push_back(tx_data);
            bcyc_q.push_back(cyc);
         end
         if (prev_hold && (!tx_valid || (tx_data != prev_data)))
            hs_err = hs_err + 1;
      end
      prev_hold = reset_n && tx_valid && !tx_ready;
      prev_data = tx_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checks = checks + 1;
      if (got !== expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_50);
         #1;
         if (rand_ready)
            tx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input int cycles);
      enable   = en;
      tx_ready = rdy;
      step(cycles);
   endtask

   task automatic wait_latch(input int n, input int limit, input string tag);
      int k;
      k = 0;
      while ((latch_q.size() < n) && (k < limit)) begin
         step(1);
         k++;
      end
      checkOutput(tag, latch_q.size(), n);
   endtask

   initial begin
      int lb;
      int cb;
      int bb;
      int set_cyc;
      int k;

      nom_exp = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67};
      reset_n    = 1'b0;
      enable     = 1'b0;
      tx_ready   = 1'b0;
      ch0        = '0;
      ch1        = '0;
      rand_ready = 1'b0;

      $display("[TB] reset with random inputs");
      for (int i = 0; i < 3; i++) begin
         enable   = 1'($urandom_range(0, 1));
         tx_ready = 1'($urandom_range(0, 1));
         ch0      = $urandom;
         ch1      = $urandom;
         step(1);
         checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
         checkOutput("rst_pulses_busy", {29'd0, counter_latch, counter_clear, busy}, 32'd0);
      end
      checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
      checkOutput("rst_ch_sel", {28'd0, ch_sel}, 32'd0);
      checkOutput("rst_overrun", {24'd0, overrun_cnt}, 32'd0);

      ch0 = 32'h11223344;
      ch1 = 32'hDEADBEEF;
      applyStimulus(1'b0, 1'b1, 1);
      reset_n = 1'b1;
      step(5);
      checkOutput("idle_no_pulses", latch_q.size() + clear_q.size(), 0);

      $display("[TB] nominal frame");
      lb = latch_q.size(); cb = clear_q.size(); bb = byte_q.size();
      set_cyc = cyc;
      enable = 1'b1;
      wait_latch(lb + 1, 150, "nom_latch_seen");
      step(20);
      checkOutput("nom_clear_delay", clear_q[cb] - set_cyc, 2);
      checkOutput("nom_latch_spacing", latch_q[lb] - clear_q[cb], 100);
      checkOutput("nom_byte_count", byte_q.size() - bb, 11);
      for (int i = 0; i < 11; i++)
         checkOutput($sformatf("nom_byte%0d", i), {24'd0, byte_q[bb + i]}, {24'd0, nom_exp[i]});
      checkOutput("nom_first_byte_latency", bcyc_q[bb] - latch_q[lb], 1);
      checkOutput("nom_load_gap", bcyc_q[bb + 6] - bcyc_q[bb + 5], 2);
      checkOutput("nom_frame_duration", bcyc_q[bb + 10] - latch_q[lb], 13);
      checkOutput("nom_busy_after", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] backpressure");
      lb = latch_q.size(); bb = byte_q.size();
      applyStimulus(1'b1, 1'b0, 0);
      wait_latch(lb + 1, 150, "bp_first_latch");
      step(250);
      tx_ready = 1'b1;
      wait_latch(lb + 2, 100, "bp_second_latch");
      step(20);
      checkOutput("bp_overrun", {24'd0, overrun_cnt}, 32'd2);
      checkOutput("bp_latch_spacing", latch_q[lb + 1] - latch_q[lb], 300);
      checkOutput("bp_byte_count", byte_q.size() - bb, 22);
      checkOutput("bp_nwin_first", {24'd0, byte_q[bb + 1]}, 32'h01);
      checkOutput("bp_nwin_second", {24'd0, byte_q[bb + 12]}, 32'h03);
      checkOutput("bp_csum_second", {24'd0, byte_q[bb + 21]}, 32'h65);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] csum transfer on terminal count");
      lb = latch_q.size(); bb = byte_q.size();
      applyStimulus(1'b1, 1'b0, 0);
      wait_latch(lb + 1, 150, "sim_first_latch");
      step(87);
      tx_ready = 1'b1;
      wait_latch(lb + 2, 40, "sim_second_latch");
      step(20);
      checkOutput("sim_latch_spacing", latch_q[lb + 1] - latch_q[lb], 100);
      checkOutput("sim_overrun_unchanged", {24'd0, overrun_cnt}, 32'd2);
      checkOutput("sim_csum_cycle", bcyc_q[bb + 10], latch_q[lb + 1]);
      checkOutput("sim_csum_value", {24'd0, byte_q[bb + 10]}, 32'h67);
      checkOutput("sim_next_sync", {24'd0, byte_q[bb + 11]}, 32'hA5);
      checkOutput("sim_next_sync_cycle", bcyc_q[bb + 11] - latch_q[lb + 1], 1);
      checkOutput("sim_next_nwin", {24'd0, byte_q[bb + 12]}, 32'h01);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] enable drop mid-frame");
      lb = latch_q.size(); cb = clear_q.size(); bb = byte_q.size();
      applyStimulus(1'b1, 1'b1, 0);
      wait_latch(lb + 1, 150, "drop_latch");
      step(3);
      applyStimulus(1'b0, 1'b1, 150);
      checkOutput("drop_byte_count", byte_q.size() - bb, 11);
      checkOutput("drop_csum", {24'd0, byte_q[bb + 10]}, 32'h67);
      checkOutput("drop_no_latch", latch_q.size() - lb, 1);
      checkOutput("drop_no_clear", clear_q.size() - cb, 1);
      set_cyc = cyc;
      enable = 1'b1;
      wait_latch(lb + 2, 150, "reenable_latch");
      checkOutput("reenable_clear_delay", clear_q[cb + 1] - set_cyc, 2);
      checkOutput("reenable_latch_spacing", latch_q[lb + 1] - clear_q[cb + 1], 100);
      step(20);

      $display("[TB] reset mid-DATA with random tx_ready");
      rand_ready = 1'b1;
      lb = latch_q.size();
      wait_latch(lb + 1, 150, "rmid_latch");
      bb = byte_q.size();
      k = 0;
      while ((byte_q.size() < bb + 3) && (k < 300)) begin
         step(1);
         k++;
      end
      checkOutput("rmid_bytes_reached", byte_q.size() - bb, 3);
      checkOutput("rmid_valid_before", {31'd0, tx_valid}, 32'd1);
      reset_n = 1'b0;
      step(1);
      checkOutput("rmid_valid_dropped", {31'd0, tx_valid}, 32'd0);
      checkOutput("rmid_busy_dropped", {31'd0, busy}, 32'd0);
      reset_n = 1'b1;
      step(5);
      rand_ready = 1'b0;
      checkOutput("rmid_still_idle", {30'd0, busy, tx_valid}, 32'd0);
      checkOutput("handshake_hold", hs_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
